// File: rtl/serial_defs.sv
// Register map, status layout and shared encodings for the serial transmitter and receiver.
package serial_defs;

    localparam int   DEFAULT_CLKS_PER_BIT = 434;  // 115200 baud from a 50 MHz clock
    localparam int   DATA_BITS            = 8;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int   STATUS_READY_BIT    = 0;
    localparam int   STATUS_IDLE_BIT     = 1;
    localparam int   STATUS_OVERFLOW_BIT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/serial_tx_fifo.sv
// Power-of-two transmit FIFO with show-ahead read data; overflowing pushes and empty pops are ignored.
module serial_tx_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Bus-programmed 8N1 serial transmitter: data writes fill a FIFO, the FSM shifts bytes out LSB first on txd.
module serial_tx
    import serial_defs::*;
#(
    parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       wr,
    input  logic       addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       txd
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e              state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   txd_q, txd_d;
    logic                   overflow_q, overflow_d;

    logic                   data_wr, status_rd, baud_done;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0]   fifo_head;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic [7:0]             status;

    assign data_wr   = en & wr & (addr == ADDR_DATA);
    assign status_rd = en & ~wr & (addr == ADDR_STATUS);
    // Fullness is the pre-edge value, so a write into a full FIFO drops even if a pop frees a slot.
    assign fifo_push = data_wr & ~fifo_full;
    assign baud_done = (baud_q == BAUD_LAST);

    serial_tx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (data_in),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_done ? '0 : baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_done) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // txd is computed from the next state so the line changes on the same edge as the FSM.
        txd_d = 1'b1;
        if (state_d == START)     txd_d = 1'b0;
        else if (state_d == DATA) txd_d = shift_d[0];

        overflow_d = overflow_q;
        if (status_rd)              overflow_d = 1'b0;
        if (data_wr && fifo_full)   overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        status                      = 8'h00;
        status[STATUS_READY_BIT]    = ~fifo_full;
        status[STATUS_IDLE_BIT]     = (fifo_count == '0) && (state_q == IDLE);
        status[STATUS_OVERFLOW_BIT] = overflow_q;
        data_out = (addr == ADDR_STATUS) ? status : 8'h00;
    end

    assign txd = txd_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: frame monitor checks decoded bytes against a write scoreboard.
module tb_serial_tx;

    localparam int CPB          = 4;
    localparam int FRAME_CYCLES = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       wr;
    logic       addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       txd;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         cyc          = 0;
    int         frames_seen  = 0;
    logic [7:0] exp_q[$];
    int         start_cyc_q[$];

    serial_tx #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .txd      (txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame decoder: start bit detected at its first negedge, bits sampled mid-bit.
    initial begin : monitor
        logic [7:0] got;
        logic       start_bit;
        logic       stop_bit;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && txd === 1'b0) begin
                start_cyc_q.push_back(cyc);
                got       = 8'h00;
                start_bit = 1'bx;
                stop_bit  = 1'bx;
                aborted   = 1'b0;
                for (int off = 1; off <= 38; off++) begin
                    @(negedge clk);
                    if (reset === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (off == 2) start_bit = txd;
                    else if (off == 38) stop_bit = txd;
                    else if (off >= 6 && (off % 4) == 2) got = {txd, got[7:1]};
                end
                if (!aborted) begin
                    tests_run++;
                    if (start_bit !== 1'b0 || stop_bit !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL frame_framing: start=%b stop=%b, required start=0 stop=1", start_bit, stop_bit);
                    end
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL frame_unexpected: got 0x%02h, required no frame", got);
                    end else begin
                        logic [7:0] want;
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            tests_failed++;
                            $display("FAIL frame_data: got 0x%02h, required 0x%02h", got, want);
                        end
                    end
                    frames_seen++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic bus_write(input logic a, input logic [7:0] d);
        en = 1'b1; wr = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        en = 1'b0; wr = 1'b0; addr = 1'b1;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (frames_seen < target) begin
            tests_failed++;
            $display("FAIL wait_frames: saw %0d frames, required %0d", frames_seen, target);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; wr = 1'b0; addr = 1'b1; data_in = 8'h00;
        repeat (3) @(negedge clk);
        tests_run++;
        if (txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_txd: got %b, required 1", txd);
        end
        tests_run++;
        if (data_out !== 8'h03) begin
            tests_failed++;
            $display("FAIL reset_status: got 0x%02h, required 0x03", data_out);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (data_out !== 8'h03 || txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: status 0x%02h txd %b, required 0x03 and 1", data_out, txd);
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] frame;
        frame = {1'b1, 8'h55, 1'b0};
        exp_q.push_back(8'h55);
        bus_write(1'b0, 8'h55);
        tests_run++;
        if (txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_latency: txd %b before next edge, required 1", txd);
        end
        for (int i = 0; i < FRAME_CYCLES; i++) begin
            @(negedge clk);
            tests_run++;
            if (txd !== frame[i / CPB]) begin
                tests_failed++;
                $display("FAIL single_bit: cycle %0d txd %b, required %b", i, txd, frame[i / CPB]);
            end
            if (i == 20) begin
                tests_run++;
                if (data_out !== 8'h01) begin
                    tests_failed++;
                    $display("FAIL single_busy_status: got 0x%02h, required 0x01", data_out);
                end
            end
        end
        @(negedge clk);
        tests_run++;
        if (data_out !== 8'h03 || txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_done: status 0x%02h txd %b, required 0x03 and 1", data_out, txd);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int base;
        int gap;
        base = frames_seen;
        start_cyc_q.delete();
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        bus_write(1'b0, 8'hA3);
        bus_write(1'b0, 8'h0F);
        wait_frames(base + 2, 4 * FRAME_CYCLES);
        gap = (start_cyc_q.size() >= 2) ? start_cyc_q[1] - start_cyc_q[0] : -1;
        tests_run++;
        if (gap != FRAME_CYCLES) begin
            tests_failed++;
            $display("FAIL b2b_gap: start-to-start %0d cycles, required %0d", gap, FRAME_CYCLES);
        end
        tests_run++;
        if (data_out !== 8'h03) begin
            tests_failed++;
            $display("FAIL b2b_status: got 0x%02h, required 0x03", data_out);
        end
    endtask

    task automatic test_overflow();
        int base;
        base = frames_seen;
        for (int i = 1; i <= 6; i++) begin
            logic [7:0] b;
            b = 8'(i * 8'h11);
            if (i <= 5) exp_q.push_back(b);
            bus_write(1'b0, b);
        end
        en = 1'b1; wr = 1'b0; addr = 1'b1;
        #1;
        tests_run++;
        if (data_out !== 8'h04) begin
            tests_failed++;
            $display("FAIL ovf_first_read: got 0x%02h, required 0x04", data_out);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL ovf_second_read: got 0x%02h, required 0x00", data_out);
        end
        en = 1'b0;
        wait_frames(base + 5, 8 * FRAME_CYCLES);
        repeat (2 * FRAME_CYCLES) @(negedge clk);
        tests_run++;
        if (frames_seen != base + 5) begin
            tests_failed++;
            $display("FAIL ovf_frame_count: got %0d frames, required 5", frames_seen - base);
        end
        tests_run++;
        if (data_out !== 8'h03) begin
            tests_failed++;
            $display("FAIL ovf_final_status: got 0x%02h, required 0x03", data_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        int lows;
        exp_q.push_back(8'h00);
        bus_write(1'b0, 8'h00);
        @(negedge clk);
        tests_run++;
        if (txd !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_start_bit: txd %b, required 0", txd);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_in_start: txd %b, required 1", txd);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        exp_q.push_back(8'hFF);
        bus_write(1'b0, 8'hFF);
        repeat (18) @(negedge clk);
        tests_run++;
        if (data_out !== 8'h01) begin
            tests_failed++;
            $display("FAIL rst_busy_status: got 0x%02h, required 0x01", data_out);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (txd !== 1'b1 || data_out !== 8'h03) begin
            tests_failed++;
            $display("FAIL rst_in_data: txd %b status 0x%02h, required 1 and 0x03", txd, data_out);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (data_out !== 8'h03) begin
            tests_failed++;
            $display("FAIL rst_release_status: got 0x%02h, required 0x03", data_out);
        end
        base = frames_seen;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        tests_run++;
        if (lows != 0 || frames_seen != base) begin
            tests_failed++;
            $display("FAIL rst_no_resume: %0d low cycles %0d frames, required 0 and 0", lows, frames_seen - base);
        end
    endtask

    task automatic test_read_path();
        int base;
        int lows;
        en = 1'b1; wr = 1'b0; addr = 1'b0;
        #1;
        tests_run++;
        if (data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL read_data_addr: got 0x%02h, required 0x00", data_out);
        end
        @(negedge clk);
        en = 1'b0; addr = 1'b1;
        base = frames_seen;
        bus_write(1'b1, 8'hFF);
        #1;
        tests_run++;
        if (data_out !== 8'h03) begin
            tests_failed++;
            $display("FAIL status_write_ignored: got 0x%02h, required 0x03", data_out);
        end
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        tests_run++;
        if (lows != 0 || frames_seen != base) begin
            tests_failed++;
            $display("FAIL status_write_no_tx: %0d low cycles %0d frames, required 0 and 0", lows, frames_seen - base);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_read_path();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d bytes never transmitted, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
